// File: rtl/video_frame_arbiter.sv
// Frame-granular arbiter sharing one Avalon-ST sink between two live camera sources.
// Optional per-source completed-video-frame counters: define VIDEO_FRAME_ARB_STATS_EN.

module video_frame_arbiter #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              sel_i,
  input  logic              auto_rr_i,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_startofpacket,
  input  logic              s0_endofpacket,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_startofpacket,
  input  logic              s1_endofpacket,
  input  logic              s1_valid,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_startofpacket,
  output logic              m_endofpacket,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              active_src_o,
  output logic              busy_o
`ifdef VIDEO_FRAME_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  frame_count0_o,
  output logic [CNT_W-1:0]  frame_count1_o
`endif
);

  typedef enum logic [1:0] {IDLE, PASS, LOCK} state_t;

  state_t            state_q, state_d;
  logic              active_src_q;
  logic              last_served_q;
  logic [3:0]        type_q;

  logic              cand;
  logic              sel_src;
  logic [DATA_W-1:0] src_data;
  logic              src_sop, src_eop, src_valid;
  logic              fwd;
  logic              sel_ready;
  logic              accept;
  logic [3:0]        eff_type;

  // The packet type lives in the low nibble of the SOP beat.
  if (DATA_W < 4 || CNT_W < 1) begin : g_param_check
    $error("video_frame_arbiter: DATA_W must be >= 4 and CNT_W >= 1");
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    cand            = sel_i;
    sel_src         = active_src_q;
    src_data        = s0_data;
    src_sop         = s0_startofpacket;
    src_eop         = s0_endofpacket;
    src_valid       = s0_valid;
    fwd             = 1'b0;
    sel_ready       = 1'b1;
    accept          = 1'b0;
    eff_type        = type_q;
    state_d         = state_q;
    m_valid         = 1'b0;
    m_startofpacket = 1'b0;
    m_endofpacket   = 1'b0;
    m_data          = '0;
    s0_ready        = 1'b1;
    s1_ready        = 1'b1;

    // Auto mode: a lone SOP wins; simultaneous SOPs go to the source not served last.
    if (auto_rr_i) begin
      if (s0_valid && s0_startofpacket && s1_valid && s1_startofpacket)
        cand = ~last_served_q;
      else
        cand = s1_valid && s1_startofpacket;
    end

    if (state_q == IDLE) sel_src = cand;

    if (sel_src) begin
      src_data  = s1_data;
      src_sop   = s1_startofpacket;
      src_eop   = s1_endofpacket;
      src_valid = s1_valid;
    end

    // Outside PASS only SOP beats may reach the sink; everything else is flushed.
    fwd       = reset_reset_n && (state_q == PASS || src_sop);
    sel_ready = fwd ? m_ready : 1'b1;

    m_valid = fwd && src_valid;
    if (m_valid) begin
      m_data          = src_data;
      m_startofpacket = src_sop;
      m_endofpacket   = src_eop;
    end

    if (sel_src) s1_ready = sel_ready;
    else         s0_ready = sel_ready;

    accept   = m_valid && m_ready;
    eff_type = src_sop ? src_data[3:0] : type_q;

    // A presented SOP commits the grant even under backpressure, so the beat stays put.
    if (accept && src_eop)
      state_d = (eff_type == 4'd0) ? IDLE : LOCK;
    else if (state_q != PASS && m_valid)
      state_d = PASS;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      active_src_q  <= 1'b0;
      last_served_q <= 1'b1;
      type_q        <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && m_valid) begin
        active_src_q  <= cand;
        last_served_q <= cand;
      end
      if (accept && src_sop) type_q <= src_data[3:0];
    end
  end

  assign active_src_o = active_src_q;
  assign busy_o       = (state_q != IDLE);

`ifdef VIDEO_FRAME_ARB_STATS_EN
  logic             video_eop;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  assign video_eop = accept && src_eop && (eff_type == 4'd0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (video_eop) begin
      if (sel_src) cnt1_q <= cnt1_q + CNT_W'(1);
      else         cnt0_q <= cnt0_q + CNT_W'(1);
    end
  end

  assign frame_count0_o = cnt0_q;
  assign frame_count1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_video_frame_arbiter.sv
// Self-checking bench for video_frame_arbiter: queue-driven sources, scoreboard on the sink.
// Counter checks are active when VIDEO_FRAME_ARB_STATS_EN is defined (CNT_W = 2 to exercise wrap).

module tb_video_frame_arbiter;

  localparam int DATA_W = 30;
  localparam int CNT_W  = 2;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              sel_i, auto_rr_i;
  logic [DATA_W-1:0] s0_data, s1_data, m_data;
  logic              s0_sop, s0_eop, s0_valid, s0_ready;
  logic              s1_sop, s1_eop, s1_valid, s1_ready;
  logic              m_sop, m_eop, m_valid, m_ready;
  logic              active_src_o, busy_o;
`ifdef VIDEO_FRAME_ARB_STATS_EN
  logic [CNT_W-1:0]  fc0, fc1;
`endif

  beat_t s0_q[$], s1_q[$], exp_q[$];
  int    total, bad;
  int    pkt_id;
  int    cnt_model[2];
  logic  acc0, acc1;
  logic  chk_s1_rdy;

  video_frame_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .sel_i            (sel_i),
    .auto_rr_i        (auto_rr_i),
    .s0_data          (s0_data),
    .s0_startofpacket (s0_sop),
    .s0_endofpacket   (s0_eop),
    .s0_valid         (s0_valid),
    .s0_ready         (s0_ready),
    .s1_data          (s1_data),
    .s1_startofpacket (s1_sop),
    .s1_endofpacket   (s1_eop),
    .s1_valid         (s1_valid),
    .s1_ready         (s1_ready),
    .m_data           (m_data),
    .m_startofpacket  (m_sop),
    .m_endofpacket    (m_eop),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .active_src_o     (active_src_o),
    .busy_o           (busy_o)
`ifdef VIDEO_FRAME_ARB_STATS_EN
    ,
    .frame_count0_o   (fc0),
    .frame_count1_o   (fc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
`ifdef VIDEO_FRAME_ARB_STATS_EN
    check({tag, "_fc0"}, fc0, cnt_model[0]);
    check({tag, "_fc1"}, fc1, cnt_model[1]);
`endif
  endtask

  // Queue one packet on a source; forwarded ones also go into the scoreboard.
  task automatic push_pkt(input int src, input logic [3:0] typ, input int len, input bit fwd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      b.data = {src[0], pkt_id[12:0], 12'(i), (i == 0) ? typ : 4'h5};
      if (src == 0) s0_q.push_back(b);
      else          s1_q.push_back(b);
      if (fwd) exp_q.push_back(b);
    end
    if (fwd && typ == 4'd0) cnt_model[src] = (cnt_model[src] + 1) % (1 << CNT_W);
    pkt_id++;
  endtask

  task automatic push_junk(input int src, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.sop  = 1'b0;
      b.eop  = 1'b0;
      b.data = {src[0], pkt_id[12:0], 12'(i), 4'h9};
      if (src == 0) s0_q.push_back(b);
      else          s1_q.push_back(b);
    end
    pkt_id++;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((s0_q.size() + s1_q.size() + exp_q.size()) != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_drain_left"}, s0_q.size() + s1_q.size() + exp_q.size(), 0);
  endtask

  // Acceptance is judged mid-cycle, away from the edge.
  always @(negedge clk) begin
    acc0 = s0_valid & s0_ready;
    acc1 = s1_valid & s1_ready;
  end

  always @(posedge clk) begin
    beat_t b;
    #1;
    if (acc0 && s0_q.size() > 0) b = s0_q.pop_front();
    if (acc1 && s1_q.size() > 0) b = s1_q.pop_front();
    if (s0_q.size() > 0) begin
      s0_valid = 1'b1;
      {s0_sop, s0_eop, s0_data} = s0_q[0];
    end else begin
      s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0; s0_data = '0;
    end
    if (s1_q.size() > 0) begin
      s1_valid = 1'b1;
      {s1_sop, s1_eop, s1_data} = s1_q[0];
    end else begin
      s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0; s1_data = '0;
    end
  end

  // Scoreboard: every beat the sink accepts must be the next expected one.
  always @(negedge clk) begin
    beat_t e;
    if (m_valid && m_ready) begin
      e = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("m_beat", {m_sop, m_eop, m_data}, e);
    end
    if (chk_s1_rdy) check("s1_ready_flush", s1_ready, 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; pkt_id = 0;
    cnt_model[0] = 0; cnt_model[1] = 0;
    acc0 = 1'b0; acc1 = 1'b0; chk_s1_rdy = 1'b0;
    rst_n = 1'b0; sel_i = 1'b0; auto_rr_i = 1'b0; m_ready = 1'b1;
    s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0; s1_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_active", active_src_o, 1'b0);
    check("rst_s0_ready", s0_ready, 1'b1);
    check("rst_s1_ready", s1_ready, 1'b1);
    check_counts("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Manual s0: control then video packet; s1 streams and is flushed.
    chk_s1_rdy = 1'b1;
    push_pkt(0, 4'hF, 3, 1'b1);
    push_pkt(0, 4'h0, 8, 1'b1);
    for (int i = 0; i < 3; i++) push_pkt(1, 4'h0, 6, 1'b0);
    wait_drain("t1");
    chk_s1_rdy = 1'b0;
    check("t1_idle", busy_o, 1'b0);
    check("t1_active", active_src_o, 1'b0);
    check_counts("t1");

    // sel_i flips mid-frame; s1 gets the first SOP after s0's EOP.
    push_pkt(0, 4'h0, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1 sel_i = 1'b1;
    push_pkt(1, 4'h0, 5, 1'b0);
    push_junk(1, 4);
    push_pkt(1, 4'h0, 4, 1'b1);
    wait_drain("t2");
    check("t2_active", active_src_o, 1'b1);
    check("t2_idle", busy_o, 1'b0);
    check_counts("t2");

    // Round robin with simultaneous SOPs: s0, s1, s0, s1.
    @(posedge clk);
    #1 auto_rr_i = 1'b1;
    for (int f = 0; f < 4; f++) begin
      push_pkt(0, 4'h0, 4, (f % 2) == 0);
      push_pkt(1, 4'h0, 4, (f % 2) == 1);
    end
    wait_drain("t3");
    check("t3_active", active_src_o, 1'b1);
    check_counts("t3");
    @(posedge clk);
    #1 begin auto_rr_i = 1'b0; sel_i = 1'b0; end

    // Five cycles of sink backpressure in the middle of a video packet.
    push_pkt(0, 4'h0, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1 m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_s0_ready", s0_ready, 1'b0);
      check("t4_m_valid", m_valid, 1'b1);
      check("t4_m_data", m_data, exp_q[0].data);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_drain("t4");
    check_counts("t4");

    // Single-beat video packet, then a stray beat.
    push_pkt(0, 4'h0, 1, 1'b1);
    push_junk(0, 1);
    wait_drain("t5a");
    check("t5_idle", busy_o, 1'b0);
    // Single-beat control packet parks in LOCK; strays are dropped there too.
    push_pkt(0, 4'h5, 1, 1'b1);
    push_junk(0, 2);
    wait_drain("t5b");
    check("t5_lock", busy_o, 1'b1);
    push_pkt(0, 4'h0, 1, 1'b1);
    wait_drain("t5c");
    check("t5_idle2", busy_o, 1'b0);
    check_counts("t5");

    // Asynchronous reset in the middle of a packet.
    push_pkt(0, 4'h0, 8, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_m_valid", m_valid, 1'b0);
    check("t6_m_sop", m_sop, 1'b0);
    check("t6_m_eop", m_eop, 1'b0);
    check("t6_m_data", m_data, '0);
    check("t6_s0_ready", s0_ready, 1'b1);
    check("t6_s1_ready", s1_ready, 1'b1);
    check("t6_busy", busy_o, 1'b0);
    check("t6_active", active_src_o, 1'b0);
    exp_q.delete();
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    check_counts("t6_rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_pkt(0, 4'h0, 4, 1'b1);
    wait_drain("t6");
    check_counts("t6");

    // Counter wrap across five frames.
    for (int k = 0; k < 5; k++) begin
      push_pkt(0, 4'h0, 3, 1'b1);
      wait_drain("t7");
      check_counts("t7");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
